mbledhesi_shumeciklik: RTL and testbench
========================================

// Module: mbledhesi_shumeciklik
// PURPOSE
// - Parametrised multi-cycle adder/subtractor for the CPU datapath. Processes CHUNK bits per clock,
//   rippling carry between chunks through a register, so wide adds close timing at high clock rates.
// - Honours CIN, adds SUB mode, and produces COUT/OVF/ZERO flags for the ALU status register.
// - Sits between register-file read ports and the ALU result mux; START/BUSY/DONE handshake toward control unit.
// PARAMETERS
// - WIDTH  24  operand/result width in bits; must be a multiple of CHUNK
// - CHUNK   8  bits added per clock; NCH = WIDTH/CHUNK chunks (NCH >= 1)
// PORTS
// - CLK    in   1      clock, all state updates on rising edge
// - RST    in   1      asynchronous, active-high reset
// - START  in   1      request; sampled only when idle or in the DONE cycle
// - SUB    in   1      0: SHUMA = A + B + CIN; 1: SHUMA = A - B - CIN (CIN acts as borrow-in)
// - A      in   WIDTH  operand A, sampled with accepted START
// - B      in   WIDTH  operand B, sampled with accepted START
// - CIN    in   1      carry-in (SUB=0) / borrow-in (SUB=1), sampled with accepted START
// - BUSY   out  1      high while a computation is in progress
// - DONE   out  1      one-cycle pulse: result and flags valid
// - SHUMA  out  WIDTH  result; holds last result until next accepted START completes
// - COUT   out  1      raw carry out of MSB (SUB=1: 1 = no borrow, 0 = borrow)
// - OVF    out  1      two's-complement signed overflow
// - ZERO   out  1      SHUMA == 0
// BEHAVIOUR
// - RST asserted: state IDLE; BUSY, DONE, COUT, OVF = 0; SHUMA = 0; ZERO = 1; internal chunk counter = 0.
//   Reset mid-operation aborts; partial result is discarded, no DONE pulse.
// - States: IDLE -> RUN on accepted START; RUN -> FIN after chunk NCH-1; FIN -> RUN if START, else IDLE.
// - Accept: START=1 in IDLE or FIN. Latch A, Bx = SUB ? ~B : B, carry = SUB ? ~CIN : CIN, SUB. Counter = 0.
// - RUN, each edge: chunk i = A[i*CHUNK +: CHUNK] + Bx[i*CHUNK +: CHUNK] + carry; write into result
//   register slice i; carry <= chunk carry-out; counter++. Only the chunk slice changes.
// - Latency: START accepted at edge k; chunks at edges k+1..k+NCH; DONE=1 and flags valid in the cycle
//   following edge k+NCH. BUSY=1 from edge k through edge k+NCH (low when DONE is high).
// - SHUMA output register updates only at the DONE edge (no partial results visible on SHUMA).
// - Flags at DONE edge: COUT = final carry; OVF = carry into MSB XOR carry out of MSB; ZERO = (result == 0).
// - START while BUSY: ignored, no effect on the operation in flight; inputs need not be held after accept.
// - START in the DONE cycle: accepted back-to-back; prior SHUMA/flags stay until the new DONE.
// - NCH = 1: single RUN cycle; DONE one cycle after accept.
// - Arithmetic modulo 2^WIDTH; no saturation. All inputs sampled synchronously, no combinational path input->output.
// STRUCTURE
// - Shared include (alu defines): state encodings IDLE/RUN/FIN, default WIDTH/CHUNK, flag bit positions
//   in the status register.
// - One sub-module: mbledhesi_pjese - combinational CHUNK-wide adder slice (a, b, cin -> sum, cout,
//   carry-into-MSB for OVF), instantiated once and reused each cycle.
// - Top: FSM, chunk counter ($clog2(NCH) bits, min 1), operand/result shift or indexed registers, flag logic.
// TESTING (WIDTH=24, CHUNK=8 unless stated)
// - 0xFFFFFF + 0x000001, SUB=0, CIN=0 -> DONE 3 cycles after accept; SHUMA=0x000000, COUT=1, ZERO=1, OVF=0.
// - 0x7FFFFF + 0x000001, SUB=0, CIN=0 -> SHUMA=0x800000, OVF=1, COUT=0, ZERO=0.
// - 0x000010 + 0x000020, SUB=0, CIN=1 -> SHUMA=0x000031 (CIN honoured); SUB=1, A=0x000005, B=0x000007,
//   CIN=0 -> SHUMA=0xFFFFFE, COUT=0 (borrow), OVF=0.
// - 0x800000 - 0x000001, SUB=1, CIN=0 -> SHUMA=0x7FFFFF, OVF=1, COUT=1.
// - START held high continuously with new operands each DONE -> back-to-back results every 4 cycles;
//   START pulses during BUSY ignored (result unchanged, single DONE per accepted request).
// - RST asserted asynchronously mid-RUN (after chunk 1) -> BUSY=0, DONE never pulses, SHUMA=0, ZERO=1;
//   next START computes correctly. Repeat random ops vs. reference model for WIDTH/CHUNK = 24/8, 24/24, 32/4.

Source files
------------

// File: rtl/mbledhesi_shumeciklik_pkg.sv
// Shared ALU definitions for the multi-cycle adder/subtractor: FSM state
// encodings, default geometry, status-register flag positions and small
// elaboration-time helpers.
package mbledhesi_shumeciklik_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 24;
  localparam int DEF_CHUNK = 8;

  // Bit positions of the adder flags inside the ALU status register.
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_COUT = 1;
  localparam int FLAG_OVF  = 2;

  // Number of chunk steps needed for a full-width operation.
  function automatic int num_chunks(input int w, input int c);
    return w / c;
  endfunction

  // Chunk counter width; a single-chunk adder still keeps a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mbledhesi_pjese.sv
// One CHUNK-wide combinational adder slice. Besides sum and carry-out it
// exposes the carry into its top bit, which the top uses for signed
// overflow when this slice processes the most significant chunk.
module mbledhesi_pjese #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] full;

  // Plain ripple add; carry into the MSB is recovered from the MSB sum bit.
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    sum  = full[CHUNK-1:0];
    cout = full[CHUNK];
    cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];
  end

endmodule

// File: rtl/mbledhesi_shumeciklik.sv
// Multi-cycle adder/subtractor. Operands are latched on an accepted start,
// then one CHUNK slice is added per clock with the carry held in a register.
// The visible result and flags update together only when the last chunk
// completes, and done pulses for exactly one cycle afterwards.
module mbledhesi_shumeciklik
  import mbledhesi_shumeciklik_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shuma,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCH = num_chunks(WIDTH, CHUNK);
  localparam int CW  = cnt_width(NCH);
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;
  logic             carry_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nxt;

  int               base;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] sum_ch;
  logic             cout_ch;
  logic             cmsb_ch;

  // A request is taken whenever no operation is in flight (idle or done cycle).
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == LAST);
  assign busy   = (state == RUN);
  assign done   = (state == FIN);

  // Next-state logic: run for NCH chunk cycles, then one done cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = FIN;
      FIN:     state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Chunk counter: cleared on accept, stepped per chunk, wrapped after the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (accept || last)  cnt <= '0;
    else if (state == RUN)    cnt <= cnt + 1'b1;
  end

  // Select the active chunk and merge its sum into the working result.
  always_comb begin
    base    = int'(cnt) * CHUNK;
    a_ch    = a_q[base +: CHUNK];
    b_ch    = bx_q[base +: CHUNK];
    res_nxt = res_q;
    res_nxt[base +: CHUNK] = sum_ch;
  end

  mbledhesi_pjese #(
    .CHUNK (CHUNK)
  ) u_pjese (
    .a    (a_ch),
    .b    (b_ch),
    .cin  (carry_q),
    .sum  (sum_ch),
    .cout (cout_ch),
    .cmsb (cmsb_ch)
  );

  // Operand latch and chunk datapath; subtraction is A + ~B + ~borrow.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= a;
      bx_q    <= sub ? ~b : b;
      carry_q <= sub ? ~cin : cin;
    end else if (state == RUN) begin
      res_q   <= res_nxt;
      carry_q <= cout_ch;
    end
  end

  // Visible result and flags, updated only as the final chunk completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shuma <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b1;
    end else if (last) begin
      shuma <= res_nxt;
      cout  <= cout_ch;
      ovf   <= cmsb_ch ^ cout_ch;
      zero  <= (res_nxt == '0);
    end
  end

endmodule

// File: tb/tb_mbledhesi_shumeciklik.sv
// Bench for the multi-cycle adder: three geometries (24/8, 24/24, 32/4)
// driven one at a time against an arithmetic reference model.
module tb_mbledhesi_shumeciklik;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic        sub;
  logic        cin;
  logic [31:0] a;
  logic [31:0] b;

  logic        busy0, done0, cout0, ovf0, zero0;
  logic        busy1, done1, cout1, ovf1, zero1;
  logic        busy2, done2, cout2, ovf2, zero2;
  logic [23:0] s0;
  logic [23:0] s1;
  logic [31:0] s2;

  logic [2:0]  busy_v, done_v, cout_v, ovf_v, zero_v;
  logic [31:0] sh_v [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mbledhesi_shumeciklik #(.WIDTH(24), .CHUNK(8)) u_d0 (
    .clk(clk), .rst(rst), .start(start[0]), .sub(sub), .a(a[23:0]), .b(b[23:0]),
    .cin(cin), .busy(busy0), .done(done0), .shuma(s0), .cout(cout0), .ovf(ovf0), .zero(zero0));

  mbledhesi_shumeciklik #(.WIDTH(24), .CHUNK(24)) u_d1 (
    .clk(clk), .rst(rst), .start(start[1]), .sub(sub), .a(a[23:0]), .b(b[23:0]),
    .cin(cin), .busy(busy1), .done(done1), .shuma(s1), .cout(cout1), .ovf(ovf1), .zero(zero1));

  mbledhesi_shumeciklik #(.WIDTH(32), .CHUNK(4)) u_d2 (
    .clk(clk), .rst(rst), .start(start[2]), .sub(sub), .a(a), .b(b),
    .cin(cin), .busy(busy2), .done(done2), .shuma(s2), .cout(cout2), .ovf(ovf2), .zero(zero2));

  assign busy_v = {busy2, busy1, busy0};
  assign done_v = {done2, done1, done0};
  assign cout_v = {cout2, cout1, cout0};
  assign ovf_v  = {ovf2, ovf1, ovf0};
  assign zero_v = {zero2, zero1, zero0};
  assign sh_v[0] = {8'h00, s0};
  assign sh_v[1] = {8'h00, s1};
  assign sh_v[2] = s2;

  function automatic int wid(input int i);
    return (i == 2) ? 32 : 24;
  endfunction

  function automatic int nch(input int i);
    return (i == 0) ? 3 : (i == 1) ? 1 : 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact integer add/subtract, then reduce modulo 2^w and
  // range-check the signed interpretation.
  function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input logic s, input logic c, output logic [31:0] r,
                                output logic co, output logic ov, output logic z);
    longint m  = longint'(1) << w;
    longint ua = longint'(av) & (m - 1);
    longint ub = longint'(bv) & (m - 1);
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    longint full;
    longint sres;
    if (s) begin
      full = ua - ub - longint'(c);
      sres = sa - sb - longint'(c);
      co   = (full >= 0);
    end else begin
      full = ua + ub + longint'(c);
      sres = sa + sb + longint'(c);
      co   = (full >= m);
    end
    r  = 32'(full & (m - 1));
    ov = (sres >= m / 2) || (sres < -(m / 2));
    z  = (r == 32'h0);
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0000;
      2:       return 32'h8000_0000 >> $urandom_range(0, 8);
      3:       return 32'h7FFF_FFFF >> $urandom_range(0, 8);
      default: return $urandom;
    endcase
  endfunction

  // One request on instance i; optionally fires ignored start pulses while busy.
  task automatic run_op(input int i, input logic [31:0] av_in, input logic [31:0] bv_in,
                        input logic s, input logic c, input bit glitch, input string tag);
    logic [31:0] av, bv, er, prev, msk;
    logic        eco, eov, ez;
    int          lat;
    bit          seen;
    msk = (wid(i) == 32) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
    av  = av_in & msk;
    bv  = bv_in & msk;
    model(wid(i), av, bv, s, c, er, eco, eov, ez);
    @(posedge clk);
    #1;
    prev = sh_v[i];
    a = av; b = bv; sub = s; cin = c; start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
    lat  = 0;
    seen = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start[i] = 1'b0;
      if (done_v[i]) begin
        seen = 1;
        break;
      end
      chk($sformatf("%s busy_in_run", tag), 32'(busy_v[i]), 32'd1);
      chk($sformatf("%s shuma_held_in_run", tag), sh_v[i], prev);
      if (glitch && $urandom_range(0, 1) == 1) begin
        start[i] = 1'b1;
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      end
    end
    chk($sformatf("%s done_seen", tag), 32'(seen), 32'd1);
    chk($sformatf("%s latency", tag), 32'(lat), 32'(nch(i)));
    chk($sformatf("%s busy_at_done", tag), 32'(busy_v[i]), 32'd0);
    chk($sformatf("%s shuma", tag), sh_v[i], er);
    chk($sformatf("%s cout", tag), 32'(cout_v[i]), 32'(eco));
    chk($sformatf("%s ovf", tag), 32'(ovf_v[i]), 32'(eov));
    chk($sformatf("%s zero", tag), 32'(zero_v[i]), 32'(ez));
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("%s single_done", tag), 32'(done_v[i]), 32'd0);
    chk($sformatf("%s shuma_kept", tag), sh_v[i], er);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] ops_a [4];
    logic [31:0] ops_b [4];
    logic [31:0] er;
    logic        eco, eov, ez;
    int          cyc;

    rst = 1'b1; start = 3'b000; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d busy", i), 32'(busy_v[i]), 32'd0);
      chk($sformatf("rst%0d done", i), 32'(done_v[i]), 32'd0);
      chk($sformatf("rst%0d shuma", i), sh_v[i], 32'd0);
      chk($sformatf("rst%0d zero", i), 32'(zero_v[i]), 32'd1);
      chk($sformatf("rst%0d cout_ovf", i), {30'd0, cout_v[i], ovf_v[i]}, 32'd0);
    end
    rst = 1'b0;

    // Directed corner cases on the 24/8 geometry.
    run_op(0, 32'hFFFFFF, 32'h000001, 1'b0, 1'b0, 0, "wrap");
    chk("wrap const", {s0, cout0, zero0, ovf0}, {24'h000000, 3'b110});
    run_op(0, 32'h7FFFFF, 32'h000001, 1'b0, 1'b0, 0, "posovf");
    chk("posovf const", {s0, cout0, zero0, ovf0}, {24'h800000, 3'b001});
    run_op(0, 32'h000010, 32'h000020, 1'b0, 1'b1, 0, "cin");
    chk("cin const", 32'(s0), 32'h000031);
    run_op(0, 32'h000005, 32'h000007, 1'b1, 1'b0, 0, "borrow");
    chk("borrow const", {s0, cout0, ovf0}, {24'hFFFFFE, 2'b00});
    run_op(0, 32'h800000, 32'h000001, 1'b1, 1'b0, 1, "negovf");
    chk("negovf const", {s0, cout0, ovf0}, {24'h7FFFFF, 2'b11});
    run_op(1, 32'hFFFFFF, 32'h000001, 1'b0, 1'b0, 0, "nch1");

    // Back-to-back: start held high, new operands presented in each done cycle.
    for (int j = 0; j < 4; j++) begin
      ops_a[j] = $urandom & 32'hFFFFFF;
      ops_b[j] = $urandom & 32'hFFFFFF;
    end
    @(posedge clk);
    #1;
    a = ops_a[0]; b = ops_b[0]; sub = 1'b0; cin = 1'b0; start[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done0 && cyc < 40);
      model(24, ops_a[j], ops_b[j], 1'b0, 1'b0, er, eco, eov, ez);
      chk($sformatf("b2b%0d shuma", j), 32'(s0), er);
      chk($sformatf("b2b%0d cout", j), 32'(cout0), 32'(eco));
      if (j > 0) chk($sformatf("b2b%0d spacing", j), 32'(cyc), 32'd4);
      if (j < 3) begin
        a = ops_a[j + 1]; b = ops_b[j + 1];
      end else begin
        start[0] = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("b2b end done", 32'(done0), 32'd0);

    // Asynchronous reset after chunk 1 of an operation in flight.
    run_op(0, 32'h123456, 32'h111111, 1'b0, 1'b0, 0, "prerst");
    @(posedge clk);
    #1;
    a = 32'h0ABCDE; b = 32'h012345; sub = 1'b0; cin = 1'b1; start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy0), 32'd0);
    chk("midrst done", 32'(done0), 32'd0);
    chk("midrst shuma", 32'(s0), 32'd0);
    chk("midrst zero", 32'(zero0), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("midrst no_done", 32'(done0), 32'd0);
    end
    run_op(0, 32'h0ABCDE, 32'h012345, 1'b0, 1'b1, 0, "postrst");

    // Random operations on every geometry.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 40; k++) begin
        run_op(i, pick_op(), pick_op(), 1'($urandom), 1'($urandom),
               bit'($urandom_range(0, 1)), $sformatf("rnd%0d_%0d", i, k));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
